ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
EX/MEM pipeline register of the 5-stage MIPS core. It sits directly downstream of the EX-stage write-back address mux and the ALU, and latches the ALU result, the store data, the selected write-back register address and the MEM/WB control bits at the clock edge. It also supports stall (hold) and flush (bubble insertion). It provides registered-state match flags that the forwarding logic uses for EX-to-EX bypass.

Parameters:
DATA_W, 32, width of the PC, ALU result and store data.
ADDR_W, 5, width of register-file addresses.

Ports:
clk  input  1  core clock; rising edge active
rst  input  1  asynchronous reset, active-high
stall  input  1  hold all registered state this cycle
flush  input  1  load a bubble this cycle
ex_valid  input  1  EX stage holds a real instruction
ex_pc  input  DATA_W  PC of the EX instruction
ex_alu_result  input  DATA_W  ALU output
ex_store_data  input  DATA_W  forwarded rt value for stores
ex_wbadd  input  ADDR_W  write-back address from the EX write-back mux (rd or rt)
ex_regwrite  input  1  instruction writes the register file
ex_memread  input  1  load
ex_memwrite  input  1  store
ex_memtoreg  input  1  write-back source is memory
id_rs  input  ADDR_W  rs of the instruction now entering EX
id_rt  input  ADDR_W  rt of the instruction now entering EX
mem_valid  output  1  registered valid
mem_pc  output  DATA_W  registered PC
mem_alu_result  output  DATA_W  registered ALU result
mem_store_data  output  DATA_W  registered store data
mem_wbadd  output  ADDR_W  registered write-back address
mem_regwrite  output  1  registered regwrite (qualified)
mem_memread  output  1  registered memread
mem_memwrite  output  1  registered memwrite
mem_memtoreg  output  1  registered memtoreg
fwd_rs  output  1  EX/MEM result must be bypassed to rs
fwd_rt  output  1  EX/MEM result must be bypassed to rt

Behaviour:
- Reset: rst is asynchronous and active-high. While rst=1, every registered output is 0: mem_valid, all data and address fields, and all control bits. Therefore fwd_rs=fwd_rt=0.
- Update priority at each rising clk edge: flush, then stall, then load.
- Flush (flush=1, regardless of stall): load a bubble. mem_valid=0, all control bits 0, and the data, address and PC fields all cleared to 0.
- Stall (stall=1, flush=0): every register keeps its value. Outputs remain stable across any number of stall cycles.
- Load (stall=0, flush=0): latency is 1 cycle. Every field captures its ex_* input with these qualifications:
  - mem_valid <= ex_valid.
  - If ex_valid=0, all control bits load 0. The data fields still capture their inputs, but that data is don't-care downstream.
  - mem_regwrite <= ex_valid & ex_regwrite & (ex_wbadd != 0). Writes to $0 are suppressed here.
  - mem_memread and mem_memwrite are gated by ex_valid. mem_memtoreg is gated the same way.
- Forwarding flags are combinational from the registered state plus id_rs/id_rt, with no extra latency:
  - fwd_rs = mem_valid & mem_regwrite & (mem_wbadd == id_rs) & (id_rs != 0).
  - fwd_rt is the same expression using id_rt.
  - A load in EX/MEM (mem_memtoreg=1) still raises fwd_*. The hazard unit is responsible for stalling load-use and must not consume the bypass value in that case.
- Simultaneous flush and stall: flush wins and a bubble is loaded.
- Reset asserted mid-stall: outputs clear immediately, without waiting for clk. After release, the block resumes with an empty (bubble) state.
- No internal state machine other than the register contents. There is no wrap-around or overflow except in the optional counter.

Optional Feature:
Macro EX_MEM_STALL_CNT_EN.
- Defined: adds output stall_cnt (input-side none, output width 32). The counter increments on each rising edge where stall=1 & flush=0 & mem_valid=1. It wraps from 0xFFFFFFFF to 0, and rst clears it to 0.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: drive rst=1 with all inputs nonzero -> all outputs 0 immediately (before any clk edge), fwd_rs=fwd_rt=0.
- Plain load: ex_valid=1, ex_alu_result=0x0000_1234, ex_wbadd=8, ex_regwrite=1 -> after 1 edge mem_alu_result=0x1234, mem_wbadd=8, mem_regwrite=1. With id_rs=8 and id_rt=9, fwd_rs=1 and fwd_rt=0.
- $0 suppression: ex_wbadd=0, ex_regwrite=1 -> mem_regwrite=0. With id_rs=0, fwd_rs=0.
- Stall: load wbadd=5, then hold stall=1 for 3 cycles while the inputs change to wbadd=7 and result 0xFFFF -> outputs stay wbadd=5 with the old result. On release, the outputs take 7/0xFFFF after the next edge.
- Flush with stall: stall=1, flush=1, ex_memwrite=1 -> after the edge mem_valid=0, mem_memwrite=0, mem_wbadd=0, fwd flags 0.
- Counter (macro on): 4 stall cycles with valid contents, then 1 flush+stall cycle -> stall_cnt=4. Assert rst -> stall_cnt=0.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: 1-cycle latency; flush loads a bubble over stall, stall holds all state.
// Optional EX_MEM_STALL_CNT_EN adds a 32-bit counter of stalled cycles holding a valid instruction.
module ex_mem_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [ADDR_W-1:0] ex_wbadd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic              ex_memtoreg,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_pc,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [ADDR_W-1:0] mem_wbadd,
  output logic              mem_regwrite,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              mem_memtoreg,
`ifdef EX_MEM_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic              fwd_rs,
  output logic              fwd_rt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_pc         <= '0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_wbadd      <= '0;
      mem_regwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_memtoreg   <= 1'b0;
    end else if (flush) begin
      mem_valid      <= 1'b0;
      mem_pc         <= '0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_wbadd      <= '0;
      mem_regwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_memtoreg   <= 1'b0;
    end else if (!stall) begin
      mem_valid      <= ex_valid;
      mem_pc         <= ex_pc;
      mem_alu_result <= ex_alu_result;
      mem_store_data <= ex_store_data;
      mem_wbadd      <= ex_wbadd;
      // writes to $0 are dropped here so forwarding never sources a $0 result
      mem_regwrite   <= ex_valid & ex_regwrite & (ex_wbadd != '0);
      mem_memread    <= ex_valid & ex_memread;
      mem_memwrite   <= ex_valid & ex_memwrite;
      mem_memtoreg   <= ex_valid & ex_memtoreg;
    end
  end

`ifdef EX_MEM_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && !flush && mem_valid)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

  // loads still raise the flags; the hazard unit owns load-use stalling
  always_comb begin
    fwd_rs = mem_valid & mem_regwrite & (mem_wbadd == id_rs) & (id_rs != '0);
    fwd_rt = mem_valid & mem_regwrite & (mem_wbadd == id_rt) & (id_rt != '0);
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed vectors with literal checks plus a per-cycle model comparison.
module tb_ex_mem_reg;
  logic        clk, rst, stall, flush, ex_valid;
  logic [31:0] ex_pc, ex_alu_result, ex_store_data;
  logic [4:0]  ex_wbadd, id_rs, id_rt;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic        mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg;
  logic [31:0] mem_pc, mem_alu_result, mem_store_data;
  logic [4:0]  mem_wbadd;
  logic        fwd_rs, fwd_rt;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  ex_mem_reg #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_wbadd(ex_wbadd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .id_rs(id_rs), .id_rt(id_rt),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_wbadd(mem_wbadd), .mem_regwrite(mem_regwrite),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg),
`ifdef EX_MEM_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected pipeline slot contents, tracked as one record
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, res, sd;
    logic [4:0]  wb;
    logic        rw, mr, mw, mt;
  } slot_t;
  slot_t       m;
  logic [31:0] m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m     <= '0;
      m_cnt <= '0;
    end else begin
      if (stall && !flush && m.valid) m_cnt <= m_cnt + 32'd1;
      if (flush)
        m <= '0;
      else if (!stall)
        m <= '{valid: ex_valid, pc: ex_pc, res: ex_alu_result, sd: ex_store_data, wb: ex_wbadd,
               rw: ex_valid && ex_regwrite && ex_wbadd != 5'd0,
               mr: ex_valid && ex_memread, mw: ex_valid && ex_memwrite, mt: ex_valid && ex_memtoreg};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic e_rs, e_rt;
    e_rs = m.valid && m.rw && m.wb == id_rs && id_rs != 5'd0;
    e_rt = m.valid && m.rw && m.wb == id_rt && id_rt != 5'd0;
    chk("cyc_valid", 32'(mem_valid), 32'(m.valid));
    chk("cyc_pc", mem_pc, m.pc);
    chk("cyc_res", mem_alu_result, m.res);
    chk("cyc_sd", mem_store_data, m.sd);
    chk("cyc_wb", 32'(mem_wbadd), 32'(m.wb));
    chk("cyc_rw", 32'(mem_regwrite), 32'(m.rw));
    chk("cyc_mr", 32'(mem_memread), 32'(m.mr));
    chk("cyc_mw", 32'(mem_memwrite), 32'(m.mw));
    chk("cyc_mt", 32'(mem_memtoreg), 32'(m.mt));
    chk("cyc_fwd_rs", 32'(fwd_rs), 32'(e_rs));
    chk("cyc_fwd_rt", 32'(fwd_rt), 32'(e_rt));
`ifdef EX_MEM_STALL_CNT_EN
    chk("cyc_cnt", stall_cnt, m_cnt);
`endif
  end

  // apply inputs, take exactly one rising edge, return at negedge+1
  task automatic drive(input logic v, input logic [31:0] pc, res, sd, input logic [4:0] wb,
                       input logic rw, mr, mw, mt, input logic [4:0] rs, rt, input logic st, fl);
    ex_valid = v; ex_pc = pc; ex_alu_result = res; ex_store_data = sd; ex_wbadd = wb;
    ex_regwrite = rw; ex_memread = mr; ex_memwrite = mw; ex_memtoreg = mt;
    id_rs = rs; id_rt = rt; stall = st; flush = fl;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    stall = 1'b1; flush = 1'b1; ex_valid = 1'b1;
    ex_pc = 32'hdead_beef; ex_alu_result = 32'h1111_2222; ex_store_data = 32'h3333_4444;
    ex_wbadd = 5'd3; ex_regwrite = 1'b1; ex_memread = 1'b1; ex_memwrite = 1'b1; ex_memtoreg = 1'b1;
    id_rs = 5'd3; id_rt = 5'd3;
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_res", mem_alu_result, 32'd0);
    chk("rst_pc", mem_pc, 32'd0);
    chk("rst_wb", 32'(mem_wbadd), 32'd0);
    chk("rst_fwd", 32'({fwd_rs, fwd_rt}), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;

    drive(1, 32'h100, 32'h0000_1234, 32'h55, 5'd8, 1, 0, 0, 0, 5'd8, 5'd9, 0, 0);
    chk("load_res", mem_alu_result, 32'h0000_1234);
    chk("load_wb", 32'(mem_wbadd), 32'd8);
    chk("load_rw", 32'(mem_regwrite), 32'd1);
    chk("load_fwd_rs", 32'(fwd_rs), 32'd1);
    chk("load_fwd_rt", 32'(fwd_rt), 32'd0);

    drive(1, 32'h104, 32'h77, 32'h0, 5'd0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 0);
    chk("zero_rw", 32'(mem_regwrite), 32'd0);
    chk("zero_fwd_rs", 32'(fwd_rs), 32'd0);

    drive(0, 32'h108, 32'h99, 32'h0, 5'd3, 1, 1, 1, 1, 5'd3, 5'd3, 0, 0);
    chk("inv_ctrl", 32'({mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg}), 32'd0);
    chk("inv_res", mem_alu_result, 32'h99);

    drive(1, 32'h10c, 32'h2000, 32'h0, 5'd10, 1, 1, 0, 1, 5'd10, 5'd10, 0, 0);
    chk("ld_fwd", 32'({fwd_rs, fwd_rt, mem_memtoreg}), 32'b111);

    drive(1, 32'h110, 32'haaaa, 32'h0, 5'd5, 1, 0, 0, 0, 5'd5, 5'd0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h114, 32'hffff, 32'h0, 5'd7, 1, 0, 0, 0, 5'd5, 5'd7, 1, 0);
      chk("stall_wb", 32'(mem_wbadd), 32'd5);
      chk("stall_res", mem_alu_result, 32'haaaa);
    end
    drive(1, 32'h114, 32'hffff, 32'h0, 5'd7, 1, 0, 0, 0, 5'd5, 5'd7, 0, 0);
    chk("rel_wb", 32'(mem_wbadd), 32'd7);
    chk("rel_res", mem_alu_result, 32'hffff);
    chk("rel_fwd", 32'({fwd_rs, fwd_rt}), 32'b01);

    drive(1, 32'h118, 32'h5, 32'h6, 5'd9, 1, 0, 1, 0, 5'd9, 5'd9, 1, 1);
    chk("fl_valid", 32'(mem_valid), 32'd0);
    chk("fl_mw", 32'(mem_memwrite), 32'd0);
    chk("fl_wb", 32'(mem_wbadd), 32'd0);
    chk("fl_fwd", 32'({fwd_rs, fwd_rt}), 32'd0);

    drive(1, 32'h120, 32'h40, 32'hcafe, 5'd0, 0, 0, 1, 0, 5'd1, 5'd2, 0, 0);
    chk("st_sd", mem_store_data, 32'hcafe);
    chk("st_mw", 32'(mem_memwrite), 32'd1);

    drive(1, 32'h124, 32'h8, 32'h0, 5'd12, 1, 0, 0, 0, 5'd12, 5'd0, 0, 0);
    drive(1, 32'h128, 32'h9, 32'h0, 5'd13, 1, 0, 0, 0, 5'd12, 5'd0, 1, 0);
    rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(mem_valid), 32'd0);
    chk("mrst_wb", 32'(mem_wbadd), 32'd0);
    chk("mrst_fwd_rs", 32'(fwd_rs), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    drive(1, 32'h128, 32'h9, 32'h0, 5'd13, 1, 0, 0, 0, 5'd12, 5'd0, 1, 0);
    chk("resume_valid", 32'(mem_valid), 32'd0);

`ifdef EX_MEM_STALL_CNT_EN
    drive(1, 32'h130, 32'h1, 32'h0, 5'd4, 1, 0, 0, 0, 5'd0, 5'd0, 0, 0);
    for (int i = 0; i < 4; i++)
      drive(1, 32'h134, 32'h2, 32'h0, 5'd4, 1, 0, 0, 0, 5'd0, 5'd0, 1, 0);
    drive(1, 32'h134, 32'h2, 32'h0, 5'd4, 1, 0, 0, 0, 5'd0, 5'd0, 1, 1);
    chk("cnt_four", stall_cnt, 32'd4);
    rst = 1'b1;
    #1;
    chk("cnt_rst", stall_cnt, 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
`endif

    for (int i = 0; i < 60; i++)
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
